// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - shared cell codes, FSM states, game-state codes and win-line table for ttt_game_ctrl
package ttt_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    localparam logic [1:0] GS_PLAY = 2'b00;
    localparam logic [1:0] GS_WIN  = 2'b01;
    localparam logic [1:0] GS_DRAW = 2'b10;

    localparam logic [3:0] LAST_CELL = 4'd8;

    typedef enum logic [2:0] {
        S_PLAY,
        S_WAIT_BLANK,
        S_CHECK,
        S_WIN,
        S_DRAW
    } state_t;

    // Rows, then columns, then the two diagonals; scan order decides which line wins a tie
    localparam logic [3:0] LINE_CELLS [0:7][0:2] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    function automatic logic [1:0] player_mark(input logic p);
        return p ? CELL_O : CELL_X;
    endfunction

    function automatic logic [1:0] cell_get(input logic [17:0] brd, input logic [3:0] idx);
        return brd[{idx, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/ttt_game_ctrl_if.sv
// rtl/ttt_game_ctrl_if.sv - move request, blanking and board/status bundle between input logic, display and ttt_game_ctrl
interface ttt_game_ctrl_if;

    logic        move_valid;
    logic [3:0]  move_idx;
    logic        new_game;
    logic        vnotactive;

    logic [17:0] board;
    logic        player;
    logic [1:0]  game_state;
    logic        winner;
    logic [7:0]  win_line;
    logic        move_ack;
    logic        move_err;
    logic        timeout_pulse;

    modport master (
        output move_valid, move_idx, new_game, vnotactive,
        input  board, player, game_state, winner, win_line,
        input  move_ack, move_err, timeout_pulse
    );

    modport slave (
        input  move_valid, move_idx, new_game, vnotactive,
        output board, player, game_state, winner, win_line,
        output move_ack, move_err, timeout_pulse
    );

endinterface

// File: rtl/ttt_line_sel.sv
// rtl/ttt_line_sel.sv - returns the three cell codes of one win line of the board
module ttt_line_sel
    import ttt_pkg::*;
(
    input  logic [17:0] board,
    input  logic [2:0]  line_idx,
    output logic [1:0]  cell_a,
    output logic [1:0]  cell_b,
    output logic [1:0]  cell_c
);

    assign cell_a = cell_get(board, LINE_CELLS[line_idx][0]);
    assign cell_b = cell_get(board, LINE_CELLS[line_idx][1]);
    assign cell_c = cell_get(board, LINE_CELLS[line_idx][2]);

endmodule

// File: rtl/ttt_game_ctrl.sv
// rtl/ttt_game_ctrl.sv - tic-tac-toe turn sequencer and referee; TURN_TIMEOUT_EN adds turn forfeit on idle
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter logic        FIRST_PLAYER = 1'b0,
    parameter logic [31:0] TURN_TIMEOUT = 32'd250_000_000
) (
    input  logic           CLK,
    input  logic           RST,
    ttt_game_ctrl_if.slave gif
);

    state_t      state_q, state_d;
    logic [17:0] board_q, board_d;
    logic        player_q, player_d;
    logic        winner_q, winner_d;
    logic [1:0]  gs_q, gs_d;
    logic [7:0]  win_line_q, win_line_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        tmo_q, tmo_d;
    logic [3:0]  count_q, count_d;
    logic [3:0]  idx_q, idx_d;
    logic [2:0]  line_q, line_d;

    logic [1:0]  mark;
    logic [1:0]  cell_a, cell_b, cell_c;
    logic        line_match;
    logic        move_legal;

    ttt_line_sel u_line_sel (
        .board    (board_q),
        .line_idx (line_q),
        .cell_a   (cell_a),
        .cell_b   (cell_b),
        .cell_c   (cell_c)
    );

    assign mark       = player_mark(player_q);
    assign line_match = (cell_a == mark) && (cell_b == mark) && (cell_c == mark);
    assign move_legal = (gif.move_idx <= LAST_CELL) &&
                        (cell_get(board_q, gif.move_idx) == CELL_EMPTY);

`ifdef TURN_TIMEOUT_EN
    logic [31:0] tcnt_q, tcnt_d;
    logic        tcnt_hit;

    assign tcnt_hit = (tcnt_q == TURN_TIMEOUT - 32'd1);
`else
    logic unused_turn_timeout;

    assign unused_turn_timeout = ^TURN_TIMEOUT;
`endif

    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        player_d   = player_q;
        winner_d   = winner_q;
        win_line_d = win_line_q;
        count_d    = count_q;
        idx_d      = idx_q;
        line_d     = line_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        tmo_d      = 1'b0;
`ifdef TURN_TIMEOUT_EN
        tcnt_d     = '0;
`endif

        if (gif.new_game) begin
            state_d    = S_PLAY;
            board_d    = '0;
            player_d   = FIRST_PLAYER;
            winner_d   = 1'b0;
            win_line_d = '0;
            count_d    = '0;
            line_d     = '0;
        end else begin
            case (state_q)
                S_PLAY: begin
                    if (gif.move_valid && move_legal) begin
                        idx_d   = gif.move_idx;
                        state_d = S_WAIT_BLANK;
                    end else begin
                        err_d = gif.move_valid;
`ifdef TURN_TIMEOUT_EN
                        // An accepted move on the expiry cycle wins; the turn is not forfeited
                        if (tcnt_hit) begin
                            player_d = ~player_q;
                            tmo_d    = 1'b1;
                        end else begin
                            tcnt_d = tcnt_q + 32'd1;
                        end
`endif
                    end
                end
                S_WAIT_BLANK: begin
                    err_d = gif.move_valid;
                    if (gif.vnotactive) begin
                        board_d[{idx_q, 1'b0} +: 2] = mark;
                        ack_d   = 1'b1;
                        count_d = count_q + 4'd1;
                        line_d  = '0;
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    err_d = gif.move_valid;
                    if (line_match) begin
                        win_line_d = 8'd1 << line_q;
                        winner_d   = player_q;
                        state_d    = S_WIN;
                    end else if (line_q == 3'd7) begin
                        if (count_q == 4'd9) begin
                            state_d = S_DRAW;
                        end else begin
                            player_d = ~player_q;
                            state_d  = S_PLAY;
                        end
                    end else begin
                        line_d = line_q + 3'd1;
                    end
                end
                S_WIN, S_DRAW: begin
                    err_d = gif.move_valid;
                end
                default: begin
                    state_d = S_PLAY;
                end
            endcase
        end

        case (state_d)
            S_WIN:   gs_d = GS_WIN;
            S_DRAW:  gs_d = GS_DRAW;
            default: gs_d = GS_PLAY;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_PLAY;
            board_q    <= '0;
            player_q   <= FIRST_PLAYER;
            winner_q   <= 1'b0;
            gs_q       <= GS_PLAY;
            win_line_q <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= 1'b0;
            count_q    <= '0;
            idx_q      <= '0;
            line_q     <= '0;
`ifdef TURN_TIMEOUT_EN
            tcnt_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            board_q    <= board_d;
            player_q   <= player_d;
            winner_q   <= winner_d;
            gs_q       <= gs_d;
            win_line_q <= win_line_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            line_q     <= line_d;
`ifdef TURN_TIMEOUT_EN
            tcnt_q     <= tcnt_d;
`endif
        end
    end

    assign gif.board         = board_q;
    assign gif.player        = player_q;
    assign gif.game_state    = gs_q;
    assign gif.winner        = winner_q;
    assign gif.win_line      = win_line_q;
    assign gif.move_ack      = ack_q;
    assign gif.move_err      = err_q;
    assign gif.timeout_pulse = tmo_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// tb/tb_ttt_game_ctrl.sv - scoreboard bench for ttt_game_ctrl
module tb_ttt_game_ctrl;

    localparam logic FIRST = 1'b0;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    always #5 CLK = ~CLK;

    ttt_game_ctrl_if gif();

    ttt_game_ctrl #(
        .FIRST_PLAYER (FIRST),
        .TURN_TIMEOUT (32'd16)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .gif (gif)
    );

    typedef struct {
        logic        ack;
        logic [17:0] board;
    } exp_t;

    localparam int LINES [0:7][0:2] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

    exp_t        sb[$];
    int          tmo_cyc[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          ack_cnt = 0;
    int          err_cnt = 0;
    int          tmo_cnt = 0;
    int          cyc = 0;
    int          ack_base = 0;
    logic [17:0] pre_board;

    logic [17:0] m_board;
    logic        m_player;
    logic        m_winner;
    logic [1:0]  m_gs;
    logic [7:0]  m_win_line;
    int          m_count;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] first_win(input logic [17:0] b, input logic [1:0] mk);
        logic [7:0] r;
        r = '0;
        for (int l = 0; l < 8; l++) begin
            if (r == 8'h00 && b[2*LINES[l][0] +: 2] == mk &&
                b[2*LINES[l][1] +: 2] == mk && b[2*LINES[l][2] +: 2] == mk)
                r[l] = 1'b1;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_board    = '0;
        m_player   = FIRST;
        m_winner   = 1'b0;
        m_gs       = 2'b00;
        m_win_line = '0;
        m_count    = 0;
    endtask

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        exp_t e;
        if (gif.move_ack || gif.move_err) begin
            if (sb.size() == 0) begin
                check_val("sb_unexpected", {31'd0, gif.move_ack}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check_val("sb_kind_ack", {31'd0, gif.move_ack}, {31'd0, e.ack});
                check_val("sb_board", {14'd0, gif.board}, {14'd0, e.board});
            end
            if (gif.move_ack) ack_cnt++;
            else err_cnt++;
        end
        if (gif.timeout_pulse) begin
            tmo_cnt++;
            tmo_cyc.push_back(cyc);
            m_player = ~m_player;
        end
    end

    task automatic issue(input logic [3:0] idx, output logic accepted);
        exp_t e;
        int   i;
        i = int'(idx);
        @(posedge CLK); #1;
        gif.move_valid = 1'b1;
        gif.move_idx   = idx;
        pre_board = m_board;
        ack_base  = ack_cnt;
        accepted  = (m_gs == 2'b00) && (i <= 8) && (m_board[2*i +: 2] == 2'b00);
        if (accepted) m_board[2*i +: 2] = m_player ? 2'b10 : 2'b01;
        e.ack   = accepted;
        e.board = m_board;
        sb.push_back(e);
        @(posedge CLK); #1;
        gif.move_valid = 1'b0;
    endtask

    task automatic finish_move();
        int n;
        logic [7:0] w;
        n = 0;
        while (ack_cnt == ack_base && n < 300) begin
            @(posedge CLK);
            n++;
        end
        if (ack_cnt == ack_base) check_val("ack_wait_expired", 32'd0, 32'd1);
        repeat (10) @(posedge CLK);
        m_count++;
        w = first_win(m_board, m_player ? 2'b10 : 2'b01);
        if (w != 8'h00) begin
            m_gs       = 2'b01;
            m_winner   = m_player;
            m_win_line = w;
        end else if (m_count == 9) begin
            m_gs = 2'b10;
        end else begin
            m_player = ~m_player;
        end
        @(negedge CLK);
        check_val("mv_game_state", {30'd0, gif.game_state}, {30'd0, m_gs});
        check_val("mv_player", {31'd0, gif.player}, {31'd0, m_player});
        check_val("mv_win_line", {24'd0, gif.win_line}, {24'd0, m_win_line});
        check_val("mv_winner", {31'd0, gif.winner}, {31'd0, m_winner});
    endtask

    task automatic play(input logic [3:0] idx);
        logic acc;
        issue(idx, acc);
        if (acc) finish_move();
        else repeat (3) @(posedge CLK);
    endtask

    task automatic new_game_pulse();
        @(posedge CLK); #1;
        gif.new_game = 1'b1;
        @(posedge CLK); #1;
        gif.new_game = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   a0, e0, t0;
        logic p0;
        logic [3:0] draw_seq [0:8];
        draw_seq = '{4'd4, 4'd0, 4'd2, 4'd6, 4'd3, 4'd5, 4'd1, 4'd7, 4'd8};

        gif.move_valid = 1'b0;
        gif.move_idx   = '0;
        gif.new_game   = 1'b0;
        gif.vnotactive = 1'b1;
        model_reset();

        repeat (2) @(negedge CLK);
        check_val("rst_board", {14'd0, gif.board}, 32'd0);
        check_val("rst_player", {31'd0, gif.player}, {31'd0, FIRST});
        check_val("rst_game_state", {30'd0, gif.game_state}, 32'd0);
        check_val("rst_win_line", {24'd0, gif.win_line}, 32'd0);
        check_val("rst_ack", {31'd0, gif.move_ack}, 32'd0);
        check_val("rst_err", {31'd0, gif.move_err}, 32'd0);
        check_val("rst_timeout", {31'd0, gif.timeout_pulse}, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b1;

        // X wins on the top row
        play(4'd0); play(4'd3); play(4'd1); play(4'd4); play(4'd2);
        check_val("win_acks", ack_cnt, 32'd5);
        check_val("win_line_row0", {24'd0, gif.win_line}, 32'h01);
        e0 = err_cnt;
        play(4'd5);
        check_val("post_win_err", err_cnt, e0 + 1);
        check_val("post_win_state", {30'd0, gif.game_state}, 32'd1);

        new_game_pulse();
        @(negedge CLK);
        check_val("ng_board", {14'd0, gif.board}, 32'd0);
        check_val("ng_player", {31'd0, gif.player}, {31'd0, FIRST});
        check_val("ng_state", {30'd0, gif.game_state}, 32'd0);
        check_val("ng_win_line", {24'd0, gif.win_line}, 32'd0);

        // Commit held off until vertical blanking
        gif.vnotactive = 1'b0;
        issue(4'd4, acc);
        repeat (100) @(posedge CLK);
        @(negedge CLK);
        check_val("hold_board", {14'd0, gif.board}, {14'd0, pre_board});
        check_val("hold_no_ack", ack_cnt, ack_base);
        @(posedge CLK); #1;
        gif.vnotactive = 1'b1;
        finish_move();
        check_val("cell4_x", {30'd0, gif.board[9:8]}, 32'd1);

        // Occupied cell and out-of-range index
        e0 = err_cnt;
        play(4'd4);
        play(4'd9);
        @(negedge CLK);
        check_val("illegal_errs", err_cnt, e0 + 2);
        check_val("illegal_board", {14'd0, gif.board}, {14'd0, m_board});
        check_val("illegal_player", {31'd0, gif.player}, {31'd0, m_player});
        check_val("illegal_state", {30'd0, gif.game_state}, 32'd0);

        // Full board, no line: draw
        new_game_pulse();
        for (int k = 0; k < 9; k++) play(draw_seq[k]);
        check_val("draw_state", {30'd0, gif.game_state}, 32'd2);
        check_val("draw_win_line", {24'd0, gif.win_line}, 32'd0);

        // new_game with move_valid cancels a pending commit
        new_game_pulse();
        gif.vnotactive = 1'b0;
        issue(4'd0, acc);
        check_val("cancel_accepted", {31'd0, acc}, 32'd1);
        gif.new_game   = 1'b1;
        gif.move_valid = 1'b1;
        gif.move_idx   = 4'd5;
        check_val("cancel_pending", sb.size(), 32'd1);
        sb.delete();
        a0 = ack_cnt;
        e0 = err_cnt;
        @(posedge CLK); #1;
        gif.new_game   = 1'b0;
        gif.move_valid = 1'b0;
        model_reset();
        gif.vnotactive = 1'b1;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        check_val("cancel_no_ack", ack_cnt, a0);
        check_val("cancel_no_err", err_cnt, e0);
        check_val("cancel_board", {14'd0, gif.board}, 32'd0);
        check_val("cancel_player", {31'd0, gif.player}, {31'd0, FIRST});

`ifdef TURN_TIMEOUT_EN
        new_game_pulse();
        tmo_cyc.delete();
        repeat (60) @(posedge CLK);
        @(negedge CLK);
        check_val("tmo_count_ge3", {31'd0, tmo_cyc.size() >= 3}, 32'd1);
        for (int k = 1; k < tmo_cyc.size(); k++)
            check_val("tmo_period", tmo_cyc[k] - tmo_cyc[k-1], 32'd16);
        check_val("tmo_player", {31'd0, gif.player}, {31'd0, m_player});
        check_val("tmo_board", {14'd0, gif.board}, 32'd0);
`else
        t0 = tmo_cnt;
        p0 = gif.player;
        repeat (40) @(posedge CLK);
        @(negedge CLK);
        check_val("no_tmo_pulse", tmo_cnt, t0);
        check_val("no_tmo_player", {31'd0, gif.player}, {31'd0, p0});
`endif

        check_val("sb_drain", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ttt_game_ctrl.md
Name: ttt_game_ctrl

Overview:
- Turn sequencer and referee for the 3x3 tic-tac-toe board shown by the VGA display path.
- Accepts debounced single-cycle move requests and validates them.
- Commits each legal move to the board register only during vertical blanking, so no frame is drawn mid-update.
- Scans the eight win lines serially, then advances the turn or ends the game. Owns board, turn and game-state registers; the display only reads them.

Parameters:
- FIRST_PLAYER, 1'b0, player who moves first after reset or new_game (0 = X, 1 = O).
- TURN_TIMEOUT, 32'd250_000_000, idle cycles in S_PLAY before the turn is forfeited (used only with TURN_TIMEOUT_EN).

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-low reset
- move_valid  in  1  one-cycle move request pulse (from falling-edge detect)
- move_idx  in  4  target cell, row*3+col, legal range 0..8
- new_game  in  1  one-cycle pulse; restarts the game
- vnotactive  in  1  high during vertical blanking
- board  out  18  cell i at bits [2i+1:2i]; 00 empty, 01 X, 10 O (11 never driven)
- player  out  1  side to move
- game_state  out  2  00 PLAY, 01 WIN, 10 DRAW
- winner  out  1  valid when game_state==WIN
- win_line  out  8  one-hot winning line, 0 unless WIN
- move_ack  out  1  pulse on the cycle a move is written
- move_err  out  1  pulse on the cycle after a rejected request
- timeout_pulse  out  1  pulse on turn forfeit; tied 0 without TURN_TIMEOUT_EN

Behaviour:
- Reset: board=0, player=FIRST_PLAYER, S_PLAY, game_state=00, winner=0, win_line=0, move_ack=0, move_err=0, timeout_pulse=0, move_count=0, line_idx=0.
- Internal FSM states: S_PLAY, S_WAIT_BLANK, S_CHECK, S_WIN, S_DRAW. game_state is 00 in the first three states.
- S_PLAY, move request:
  - move_idx<=8 and the cell is empty: latch idx, go to S_WAIT_BLANK.
  - Otherwise: move_err=1 next cycle, state unchanged.
- Requests arriving in any other state are rejected with move_err; they are not queued.
- S_WAIT_BLANK:
  - On the first cycle with vnotactive=1, write the player's mark to the latched cell and pulse move_ack.
  - Same edge: move_count+1, line_idx=0, go to S_CHECK.
  - If already blanking, the commit happens one cycle after acceptance.
- S_CHECK scans one line per cycle, in line_idx order:
  - 0-2 rows {0,1,2} {3,4,5} {6,7,8}
  - 3-5 columns {0,3,6} {1,4,7} {2,5,8}
  - 6 diagonal {0,4,8}, 7 anti-diagonal {2,4,6}
- Line check result:
  - Line matches (all three cells equal the current player's mark): win_line[line_idx]=1, winner=player, go to S_WIN.
  - line_idx==7 with no match and move_count==9: go to S_DRAW.
  - line_idx==7 with no match otherwise: toggle player, go to S_PLAY.
  - Otherwise: line_idx+1.
- Worst-case latency from commit to next S_PLAY is 8 cycles.
- A win on the ninth move is WIN, not DRAW.
- S_WIN and S_DRAW: hold all outputs until new_game.
- new_game:
  - Valid in any state.
  - Next edge: board=0, player=FIRST_PLAYER, move_count=0, win_line=0, winner=0, go to S_PLAY.
  - Overrides a simultaneous move_valid (no ack, no err).
  - Overrides a pending commit in S_WAIT_BLANK.
- Outputs are registered and update only on edges, so the board never holds an undefined encoding.

Optional Feature:
- Macro: TURN_TIMEOUT_EN.
- Defined:
  - A 32-bit counter increments each cycle in S_PLAY and clears on leaving S_PLAY or on new_game.
  - Rejected requests do not clear it.
  - When it reaches TURN_TIMEOUT-1: toggle player, pulse timeout_pulse, clear the counter. The board is unchanged.
- Undefined: no counter is present, timeout_pulse=0, and a turn waits indefinitely.

Decomposition:
- Package ttt_pkg holds:
  - CELL_EMPTY/CELL_X/CELL_O 2-bit constants
  - FSM state typedef
  - game_state codes
  - 8x3 line-to-cell index table
- One sub-module: ttt_line_sel, a combinational block taking board and line_idx and returning the three cell codes. The FSM compares them against the player's mark.

Test Plan:
- X at 0, O at 3, X at 1, O at 4, X at 2, with vnotactive held high → five move_ack pulses; game_state=01, winner=0, win_line=8'h01; further moves give move_err.
- Move to cell 4 while vnotactive=0 for 100 cycles → board unchanged until vnotactive rises; move_ack fires that cycle; board[9:8]=01.
- Move to an occupied cell, then move_idx=9 → move_err pulse for each; board, player and state unchanged.
- Sequence X4,O0,X2,O6,X3,O5,X1,O7,X8 → game_state=10, win_line=0.
- new_game asserted together with move_valid during S_WAIT_BLANK → board=0, player=FIRST_PLAYER, no move_ack.
- With TURN_TIMEOUT_EN and TURN_TIMEOUT=16, no moves → timeout_pulse every 16 cycles; player toggles each time.
